control_sequencer: RTL and testbench

//  Hardwired Moore control unit that drives the datapath's control inputs.

---
 rtl/control_sequencer.sv | 114 +++++++++++
 tb/tb_control_sequencer.sv | 126 ++++++++++++
 2 files changed

// File: rtl/control_sequencer.sv
// control_sequencer: hardwired Moore fetch/decode/execute controller driving the datapath strobes from IR.
module control_sequencer #(
  parameter int OPW     = 5,
  parameter int NREG    = 16,
  parameter int COUNT_W = 32
) (
  input  logic               clk,
  input  logic               clr,
  input  logic               run,
  input  logic               mem_ready,
  input  logic [31:0]        ir,
  output logic               PCout,
  output logic               MARin,
  output logic               incPC,
  output logic               Zin,
  output logic               ZLowOut,
  output logic               ZHighOut,
  output logic               PCin,
  output logic               Read,
  output logic               MDRin,
  output logic               MDRout,
  output logic               IRin,
  output logic               Yin,
  output logic               Cout,
  output logic               HIin,
  output logic               LOin,
  output logic [NREG-1:0]    reg_in,
  output logic [NREG-1:0]    reg_out,
  output logic [OPW-1:0]     alu_op,
  output logic               busy,
  output logic               halted,
  output logic [COUNT_W-1:0] instr_count
);
  typedef enum logic [3:0] {IDLE, T0, T1, T2, T3, T4, T5, T6, HALT} state_t;
  state_t state, state_nx;
  logic [OPW-1:0] op, imm_op;
  logic [3:0] ra, rb, rc;
  logic [NREG-1:0] one;
  logic r_type, imm, mul_div, unary, hlt, nop, retire;
  assign op      = ir[31 -: OPW];
  assign ra      = ir[26:23];
  assign rb      = ir[22:19];
  assign rc      = ir[18:15];
  assign one     = NREG'(1);
  assign r_type  = op >= OPW'(3) && op <= OPW'(11);
  assign imm     = op >= OPW'(12) && op <= OPW'(14);
  assign mul_div = op == OPW'(15) || op == OPW'(16);
  assign unary   = op == OPW'(17) || op == OPW'(18);
  assign hlt     = op == OPW'(27);
  assign nop     = !(r_type || imm || mul_div || unary || hlt);
  assign imm_op  = op == OPW'(12) ? OPW'(3) : op == OPW'(13) ? OPW'(5) : OPW'(6);
  // Last execute cycle of each opcode class; the counter advances as it is left.
  assign retire  = (state == T2 && nop) || (state == T4 && unary) ||
                   (state == T5 && (r_type || imm)) || state == T6;
  assign busy    = state != IDLE && state != HALT;
  assign halted  = state == HALT;
  always_ff @(posedge clk) begin
    if (clr) begin
      state       <= IDLE;
      instr_count <= '0;
    end else begin
      state       <= state_nx;
      instr_count <= retire ? instr_count + COUNT_W'(1) : instr_count;
    end
  end
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = run ? T0 : IDLE;
      T0:      state_nx = T1;
      T1:      state_nx = mem_ready ? T2 : T1;
      T2:      state_nx = hlt ? HALT : T3;
      T3:      state_nx = T4;
      T4:      state_nx = T5;
      T5:      state_nx = T6;
      T6:      state_nx = IDLE;
      default: state_nx = HALT;
    endcase
    if (retire) state_nx = run ? T0 : IDLE;
  end
  always_comb begin
    {PCout, MARin, incPC, Zin, ZLowOut, ZHighOut, PCin, Read} = '0;
    {MDRin, MDRout, IRin, Yin, Cout, HIin, LOin} = '0;
    reg_in  = '0;
    reg_out = '0;
    alu_op  = '0;
    case (state)
      T0: {PCout, MARin, incPC, Zin} = '1;
      T1: {ZLowOut, PCin, Read, MDRin} = '1;
      T2: {MDRout, IRin} = '1;
      T3: begin
        Yin     = !unary;
        Zin     = unary;
        alu_op  = unary ? op : '0;
        reg_out = one << (mul_div ? ra : rb);
      end
      T4: begin
        Zin     = !unary;
        Cout    = imm;
        ZLowOut = unary;
        alu_op  = unary ? '0 : imm ? imm_op : op;
        reg_out = unary || imm ? '0 : one << (mul_div ? rb : rc);
        reg_in  = unary ? one << ra : '0;
      end
      T5: begin
        ZLowOut = 1'b1;
        LOin    = mul_div;
        reg_in  = mul_div ? '0 : one << ra;
      end
      T6: {ZHighOut, HIin} = '1;
      default: ;
    endcase
  end
endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: random instruction stream with stalls, run drops, clr pulses and halts against a step-list model.
module tb_control_sequencer;
  logic clk = 1'b0, clr, run, mem_ready;
  logic [31:0] ir;
  logic PCout, MARin, incPC, Zin, ZLowOut, ZHighOut, PCin, Read, MDRin, MDRout, IRin, Yin, Cout, HIin, LOin;
  logic [15:0] reg_in, reg_out;
  logic [4:0] alu_op;
  logic busy, halted;
  logic [31:0] instr_count;
  int n_chk = 0, n_fail = 0;
  control_sequencer dut (
    .clk(clk), .clr(clr), .run(run), .mem_ready(mem_ready), .ir(ir),
    .PCout(PCout), .MARin(MARin), .incPC(incPC), .Zin(Zin), .ZLowOut(ZLowOut),
    .ZHighOut(ZHighOut), .PCin(PCin), .Read(Read), .MDRin(MDRin), .MDRout(MDRout),
    .IRin(IRin), .Yin(Yin), .Cout(Cout), .HIin(HIin), .LOin(LOin),
    .reg_in(reg_in), .reg_out(reg_out), .alu_op(alu_op), .busy(busy),
    .halted(halted), .instr_count(instr_count)
  );
  always #5 clk = ~clk;
  localparam logic [14:0] PCO = 15'h4000, MARI = 15'h2000, INC = 15'h1000, ZI = 15'h0800,
    ZLO = 15'h0400, ZHO = 15'h0200, PCI = 15'h0100, RD = 15'h0080, MDRI = 15'h0040,
    MDRO = 15'h0020, IRI = 15'h0010, YI = 15'h0008, CO = 15'h0004, HII = 15'h0002, LOI = 15'h0001;
  logic [51:0] q[$];
  logic [31:0] dir_ir[$] = '{32'h18228000, 32'h18228000, 32'h80118000, 32'h63100000, 32'hD8000000};
  int dir_stall[$] = '{0, 3, 1, 2, 0};
  int mode = 0, idx = 0, stall = 0, hcnt = 0, ninst = 0;
  bit built = 0, hlt_i = 0;
  logic [31:0] cnt_m = 0;
  logic [51:0] exp_v;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask
  function automatic logic [51:0] st(input logic [14:0] s, input int ri, input int ro, input int a);
    logic [15:0] i_v, o_v;
    i_v = ri < 0 ? 16'h0 : 16'h1 << ri;
    o_v = ro < 0 ? 16'h0 : 16'h1 << ro;
    return {s, i_v, o_v, 5'(a)};
  endfunction
  function automatic void build(input logic [31:0] i);
    int op, ra, rb, rc;
    op = int'(i[31:27]); ra = int'(i[26:23]); rb = int'(i[22:19]); rc = int'(i[18:15]);
    q = {};
    q.push_back(st(PCO | MARI | INC | ZI, -1, -1, 0));
    q.push_back(st(ZLO | PCI | RD | MDRI, -1, -1, 0));
    q.push_back(st(MDRO | IRI, -1, -1, 0));
    hlt_i = op == 27;
    if (op >= 3 && op <= 14) begin
      q.push_back(st(YI, -1, rb, 0));
      if (op <= 11) q.push_back(st(ZI, -1, rc, op));
      else q.push_back(st(ZI | CO, -1, -1, op == 12 ? 3 : op == 13 ? 5 : 6));
      q.push_back(st(ZLO, ra, -1, 0));
    end else if (op == 15 || op == 16) begin
      q.push_back(st(YI, -1, ra, 0));
      q.push_back(st(ZI, -1, rb, op));
      q.push_back(st(ZLO | LOI, -1, -1, 0));
      q.push_back(st(ZHO | HII, -1, -1, 0));
    end else if (op == 17 || op == 18) begin
      q.push_back(st(ZI, -1, rb, op));
      q.push_back(st(ZLO, ra, -1, 0));
    end
  endfunction
  function automatic logic [31:0] rand_ir();
    logic [31:0] r;
    r = $urandom;
    if ($urandom_range(0, 39) == 0) r[31:27] = 5'd27;
    else if (r[31:27] == 5'd27) r[31:27] = 5'(2 + $urandom_range(0, 16));
    return r;
  endfunction
  initial begin
    clr = 1'b1; run = 1'b0; mem_ready = 1'b0; ir = '0;
    repeat (2) @(posedge clk);
    #1 clr = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      if (c > 0) begin
        @(posedge clk);
        #1;
      end
      if (mode == 1 && idx == 0 && !built) begin
        ir = dir_ir.size() > 0 ? dir_ir.pop_front() : rand_ir();
        stall = dir_stall.size() > 0 ? dir_stall.pop_front() : $urandom_range(0, 3);
        build(ir);
        built = 1;
        ninst++;
      end
      #1;
      exp_v = mode == 1 ? q[idx] : '0;
      check("strobes", 64'({PCout, MARin, incPC, Zin, ZLowOut, ZHighOut, PCin, Read, MDRin,
                            MDRout, IRin, Yin, Cout, HIin, LOin}), 64'(exp_v[51:37]));
      check("reg_in", 64'(reg_in), 64'(exp_v[36:21]));
      check("reg_out", 64'(reg_out), 64'(exp_v[20:5]));
      check("alu_op", 64'(alu_op), 64'(exp_v[4:0]));
      check("busy", 64'(busy), 64'(mode == 1));
      check("halted", 64'(halted), 64'(mode == 2));
      check("instr_count", 64'(instr_count), 64'(cnt_m));
      clr = (mode == 2 && hcnt >= 25) || (ninst > 5 && mode == 1 && $urandom_range(0, 149) == 0);
      run = ninst <= 5 ? 1'b1 : $urandom_range(0, 3) != 0;
      mem_ready = (mode == 1 && idx == 1) ? stall == 0 : 1'($urandom_range(0, 1));
      if (clr) begin
        mode = 0; cnt_m = 0; built = 0; hcnt = 0; idx = 0;
      end else if (mode == 0) begin
        if (run) begin mode = 1; idx = 0; built = 0; end
      end else if (mode == 2) begin
        hcnt++;
      end else if (idx == 1 && !mem_ready) begin
        stall--;
      end else begin
        idx++;
        if (idx == q.size()) begin
          idx = 0; built = 0;
          if (hlt_i) begin
            mode = 2; hcnt = 0;
          end else begin
            cnt_m++;
            mode = run ? 1 : 0;
          end
        end
      end
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
